// File: rtl/vga_pkg.sv
// Shared VGA types and constants for the timing block and the renderer.
// Default 640x480@60 timing, 3-bit colours and tile geometry.
package vga_pkg;

   localparam int unsigned CW   = 10;
   localparam int unsigned RGBW = 3;

   typedef logic [CW-1:0]   coord_t;
   typedef logic [RGBW-1:0] rgb_t;

   localparam int unsigned H_ACTIVE_C = 640;
   localparam int unsigned H_FP_C     = 16;
   localparam int unsigned H_SYNC_C   = 96;
   localparam int unsigned H_BP_C     = 48;
   localparam int unsigned V_ACTIVE_C = 480;
   localparam int unsigned V_FP_C     = 10;
   localparam int unsigned V_SYNC_C   = 2;
   localparam int unsigned V_BP_C     = 33;

   localparam rgb_t BLACK   = 3'b000;
   localparam rgb_t RED     = 3'b100;
   localparam rgb_t GREEN   = 3'b010;
   localparam rgb_t BLUE    = 3'b001;
   localparam rgb_t CYAN    = 3'b011;
   localparam rgb_t YELLOW  = 3'b110;
   localparam rgb_t MAGENTA = 3'b101;
   localparam rgb_t WHITE   = 3'b111;

   localparam int unsigned TILE_W     = 4;
   localparam int unsigned TILE_SHIFT = 2;

   function automatic int unsigned axis_total(
      input int unsigned a,
      input int unsigned f,
      input int unsigned s,
      input int unsigned b
   );
      return a + f + s + b;
   endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Pixel-position bundle between the timing master and the renderer.
// The renderer answers pixel_rgb combinationally for xpos/ypos.
interface vga_timing_if;
   import vga_pkg::*;

   coord_t xpos;
   coord_t ypos;
   logic   active;
   logic   tick;
   logic   frame_start;
   rgb_t   pixel_rgb;

   modport master (
      output xpos,
      output ypos,
      output active,
      output tick,
      output frame_start,
      input  pixel_rgb
   );

   modport slave (
      input  xpos,
      input  ypos,
      input  active,
      input  tick,
      input  frame_start,
      output pixel_rgb
   );

endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping counter plus active and sync decode.
// Used once per line (H) and once per frame (V).
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int unsigned ACTIVE = H_ACTIVE_C,
   parameter int unsigned FP     = H_FP_C,
   parameter int unsigned SYNC   = H_SYNC_C,
   parameter int unsigned BP     = H_BP_C,
   parameter bit          POL    = 1'b0
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   en,
   output coord_t count,
   output logic   wrap,
   output logic   in_active,
   output logic   sync
);

   localparam int unsigned TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

   // 11-bit bounds so an axis ending exactly at 1024 still compares right
   localparam logic [CW:0] LAST = (CW+1)'(TOTAL - 1);
   localparam logic [CW:0] ACT  = (CW+1)'(ACTIVE);
   localparam logic [CW:0] S_LO = (CW+1)'(ACTIVE + FP);
   localparam logic [CW:0] S_HI = (CW+1)'(ACTIVE + FP + SYNC);

   coord_t      cnt_q;
   coord_t      cnt_d;
   logic [CW:0] cnt_x;

   assign cnt_x = {1'b0, cnt_q};

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (en) cnt_d = wrap ? '0 : cnt_q + coord_t'(1);
   end

   assign count     = cnt_q;
   assign wrap      = (cnt_x == LAST);
   assign in_active = (cnt_x < ACT);
   assign sync      = (cnt_x >= S_LO && cnt_x < S_HI) ? POL : ~POL;

endmodule

// File: rtl/vga_timing.sv
// VGA pixel-timing master: divider, H/V counters, renderer interface
// and a one-pixel output register stage driving the pins.
module vga_timing
   import vga_pkg::*;
#(
   parameter int unsigned CLK_DIV  = 2,
   parameter int unsigned H_ACTIVE = H_ACTIVE_C,
   parameter int unsigned H_FP     = H_FP_C,
   parameter int unsigned H_SYNC   = H_SYNC_C,
   parameter int unsigned H_BP     = H_BP_C,
   parameter int unsigned V_ACTIVE = V_ACTIVE_C,
   parameter int unsigned V_FP     = V_FP_C,
   parameter int unsigned V_SYNC   = V_SYNC_C,
   parameter int unsigned V_BP     = V_BP_C,
   parameter bit          SYNC_POL = 1'b0
) (
   input  logic                clk,
   input  logic                reset,
   vga_timing_if.master        vif,
   output logic                vga_hsync,
   output logic                vga_vsync,
   output logic [RGBW-1:0]     vga_rgb
);

   localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div_q;
   logic [DW-1:0] div_d;
   logic          pix_en;

   coord_t h_cnt;
   coord_t v_cnt;
   logic   h_wrap;
   logic   h_act;
   logic   h_sync;
   logic   v_act;
   logic   v_sync;
   logic   unused_v_wrap;
   logic   active;

   rgb_t rgb_q;
   rgb_t rgb_d;
   logic hs_q;
   logic hs_d;
   logic vs_q;
   logic vs_d;

   // with CLK_DIV = 1 the divider sits at 0 and pix_en is constant
   assign pix_en = (div_q == DIV_LAST);

   always_comb div_d = pix_en ? '0 : div_q + DW'(1);

   always_ff @(posedge clk) begin
      if (reset) div_q <= '0;
      else       div_q <= div_d;
   end

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .POL    (SYNC_POL)
   ) u_h (
      .clk       (clk),
      .reset     (reset),
      .en        (pix_en),
      .count     (h_cnt),
      .wrap      (h_wrap),
      .in_active (h_act),
      .sync      (h_sync)
   );

   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .POL    (SYNC_POL)
   ) u_v (
      .clk       (clk),
      .reset     (reset),
      .en        (pix_en & h_wrap),
      .count     (v_cnt),
      .wrap      (unused_v_wrap),
      .in_active (v_act),
      .sync      (v_sync)
   );

   assign active = h_act & v_act;

   assign vif.xpos   = h_cnt;
   assign vif.ypos   = v_cnt;
   assign vif.active = active;
   assign vif.tick   = (v_cnt == coord_t'(V_ACTIVE));

   assign vif.frame_start = pix_en & ~reset &
                            (h_cnt == '0) & (v_cnt == '0);

   // pins lag the counters by one pixel, colour and sync together
   always_comb begin
      rgb_d = rgb_q;
      hs_d  = hs_q;
      vs_d  = vs_q;
      if (pix_en) begin
         rgb_d = active ? vif.pixel_rgb : BLACK;
         hs_d  = h_sync;
         vs_d  = v_sync;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rgb_q <= BLACK;
         hs_q  <= ~SYNC_POL;
         vs_q  <= ~SYNC_POL;
      end else begin
         rgb_q <= rgb_d;
         hs_q  <= hs_d;
         vs_q  <= vs_d;
      end
   end

   assign vga_rgb   = rgb_q;
   assign vga_hsync = hs_q;
   assign vga_vsync = vs_q;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing on a shrunken 58x19 raster, CLK_DIV 2.
// Renderer is modelled combinationally on the slave side of the bundle.
module tb_vga_timing;
   import vga_pkg::*;

   localparam int CD = 2;
   localparam int HA = 40;
   localparam int HF = 4;
   localparam int HS = 8;
   localparam int HB = 6;
   localparam int HT = 58;
   localparam int VA = 12;
   localparam int VF = 2;
   localparam int VS = 2;
   localparam int VB = 3;
   localparam int VT = 19;
   localparam int FRAME_CLK = HT * VT * CD;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       vga_hsync;
   logic       vga_vsync;
   logic [2:0] vga_rgb;
   int         checks = 0;
   int         errors = 0;
   int         mode = 0;

   vga_timing_if vif ();

   vga_timing #(
      .CLK_DIV  (CD),
      .H_ACTIVE (HA),
      .H_FP     (HF),
      .H_SYNC   (HS),
      .H_BP     (HB),
      .V_ACTIVE (VA),
      .V_FP     (VF),
      .V_SYNC   (VS),
      .V_BP     (VB),
      .SYNC_POL (1'b0)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .vif       (vif),
      .vga_hsync (vga_hsync),
      .vga_vsync (vga_vsync),
      .vga_rgb   (vga_rgb)
   );

   always #5 clk = ~clk;

   always_comb begin
      if (mode == 1)      vif.pixel_rgb = WHITE;
      else if (mode == 2) vif.pixel_rgb = vif.xpos[2:0];
      else                vif.pixel_rgb = MAGENTA;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // pin value expected while the counters show (x,y): previous pixel
   function automatic logic [2:0] exp_pin(input int x, input int y,
                                          input int m);
      int px;
      int py;
      px = x - 1;
      py = y;
      if (x == 0) begin
         px = HT - 1;
         py = (y == 0) ? VT - 1 : y - 1;
      end
      if (px < HA && py < VA) begin
         if (m == 2) return 3'(px % 8);
         return WHITE;
      end
      return BLACK;
   endfunction

   task automatic wait_frame_start(input string tag);
      for (int i = 0; i < FRAME_CLK + 10; i++) begin
         step();
         if (vif.frame_start === 1'b1) return;
      end
      checks++;
      errors++;
      $display("FAIL %s: frame_start timeout", tag);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      mode = 0;
      repeat (3) step();
      checks++;
      if (vga_hsync !== 1'b1) begin
         errors++;
         $display("FAIL rst_hsync: got %b exp 1", vga_hsync);
      end
      checks++;
      if (vga_vsync !== 1'b1) begin
         errors++;
         $display("FAIL rst_vsync: got %b exp 1", vga_vsync);
      end
      checks++;
      if (vga_rgb !== 3'b000) begin
         errors++;
         $display("FAIL rst_rgb: got %b exp 000", vga_rgb);
      end
      checks++;
      if (vif.xpos !== 10'd0 || vif.ypos !== 10'd0) begin
         errors++;
         $display("FAIL rst_pos: got %0d,%0d exp 0,0",
                  vif.xpos, vif.ypos);
      end
      checks++;
      if (vif.active !== 1'b1) begin
         errors++;
         $display("FAIL rst_active: got %b exp 1", vif.active);
      end
      checks++;
      if (vif.tick !== 1'b0 || vif.frame_start !== 1'b0) begin
         errors++;
         $display("FAIL rst_tick_fs: got %b%b exp 00",
                  vif.tick, vif.frame_start);
      end
      reset = 1'b0;
      step();
      checks++;
      if (vif.xpos !== 10'd0 || vif.frame_start !== 1'b1) begin
         errors++;
         $display("FAIL rel_clk1: xpos %0d fs %b exp 0 1",
                  vif.xpos, vif.frame_start);
      end
      step();
      checks++;
      if (vif.xpos !== 10'd1 || vif.frame_start !== 1'b0) begin
         errors++;
         $display("FAIL rel_clk2: xpos %0d fs %b exp 1 0",
                  vif.xpos, vif.frame_start);
      end
      checks++;
      if (vga_rgb !== MAGENTA) begin
         errors++;
         $display("FAIL rel_rgb: got %b exp 101", vga_rgb);
      end
   endtask

   task automatic test_line();
      int low_clks = 0;
      int first_x = -1;
      int wraps = 0;
      int ybad = 0;
      int px = int'(vif.xpos);
      int py = int'(vif.ypos);
      for (int i = 0; i < HT * CD; i++) begin
         step();
         if (vga_hsync === 1'b0) begin
            low_clks++;
            if (first_x < 0) first_x = int'(vif.xpos);
         end
         if (px == HT - 1 && int'(vif.xpos) == 0) begin
            wraps++;
            if (int'(vif.ypos) != py + 1) ybad++;
         end
         px = int'(vif.xpos);
         py = int'(vif.ypos);
      end
      checks++;
      if (low_clks != HS * CD) begin
         errors++;
         $display("FAIL hsync_width: got %0d exp %0d",
                  low_clks, HS * CD);
      end
      checks++;
      if (first_x != HA + HF + 1) begin
         errors++;
         $display("FAIL hsync_first_x: got %0d exp %0d",
                  first_x, HA + HF + 1);
      end
      checks++;
      if (wraps != 1 || ybad != 0) begin
         errors++;
         $display("FAIL line_wrap: wraps %0d ybad %0d exp 1 0",
                  wraps, ybad);
      end
   endtask

   task automatic test_frame();
      int n = 0;
      int vs_low = 0;
      int first_vy = -1;
      int tick_clks = 0;
      int tick_bad = 0;
      int act_clks = 0;
      bit seen = 1'b0;
      wait_frame_start("frame_a");
      for (int i = 0; i < FRAME_CLK + 10; i++) begin
         if (vga_vsync === 1'b0) begin
            vs_low++;
            if (first_vy < 0) first_vy = int'(vif.ypos);
         end
         if (vif.tick === 1'b1) begin
            tick_clks++;
            if (int'(vif.ypos) != VA) tick_bad++;
         end
         if (vif.active === 1'b1) act_clks++;
         step();
         n++;
         if (vif.frame_start === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen || n != FRAME_CLK) begin
         errors++;
         $display("FAIL frame_period: got %0d exp %0d", n, FRAME_CLK);
      end
      checks++;
      if (vs_low != VS * HT * CD) begin
         errors++;
         $display("FAIL vsync_width: got %0d exp %0d",
                  vs_low, VS * HT * CD);
      end
      checks++;
      if (first_vy != VA + VF) begin
         errors++;
         $display("FAIL vsync_line: got %0d exp %0d",
                  first_vy, VA + VF);
      end
      checks++;
      if (tick_clks != HT * CD || tick_bad != 0) begin
         errors++;
         $display("FAIL tick: clks %0d bad %0d exp %0d 0",
                  tick_clks, tick_bad, HT * CD);
      end
      checks++;
      if (act_clks != HA * VA * CD) begin
         errors++;
         $display("FAIL active_count: got %0d exp %0d",
                  act_clks, HA * VA * CD);
      end
   endtask

   task automatic test_rgb(input int m, input string tag);
      int bad = 0;
      int white = 0;
      int blank_bad = 0;
      logic [2:0] e;
      mode = m;
      wait_frame_start(tag);
      for (int i = 0; i < FRAME_CLK; i++) begin
         e = exp_pin(int'(vif.xpos), int'(vif.ypos), m);
         if (vga_rgb !== e) bad++;
         if (vga_rgb === WHITE) white++;
         if (int'(vif.xpos) == HA + 1 && vga_rgb !== BLACK)
            blank_bad++;
         step();
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL %s_pixels: %0d wrong samples exp 0", tag, bad);
      end
      checks++;
      if (blank_bad != 0) begin
         errors++;
         $display("FAIL %s_after_edge: %0d nonzero exp 0",
                  tag, blank_bad);
      end
      if (m == 1) begin
         checks++;
         if (white != HA * VA * CD) begin
            errors++;
            $display("FAIL %s_count: got %0d exp %0d",
                     tag, white, HA * VA * CD);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit hit = 1'b0;
      for (int i = 0; i < 2 * FRAME_CLK; i++) begin
         step();
         if (int'(vif.xpos) == 50 && int'(vif.ypos) == VA + VF) begin
            hit = 1'b1;
            break;
         end
      end
      checks++;
      if (!hit || vga_vsync !== 1'b0 || vga_hsync !== 1'b0) begin
         errors++;
         $display("FAIL mid_pre: hit %b vs %b hs %b exp 1 0 0",
                  hit, vga_vsync, vga_hsync);
      end
      reset = 1'b1;
      step();
      checks++;
      if (vga_vsync !== 1'b1 || vga_hsync !== 1'b1) begin
         errors++;
         $display("FAIL mid_sync: vs %b hs %b exp 1 1",
                  vga_vsync, vga_hsync);
      end
      checks++;
      if (vif.xpos !== 10'd0 || vif.ypos !== 10'd0 ||
          vga_rgb !== 3'b000) begin
         errors++;
         $display("FAIL mid_state: pos %0d,%0d rgb %b exp 0,0 000",
                  vif.xpos, vif.ypos, vga_rgb);
      end
      step();
      reset = 1'b0;
      step();
      checks++;
      if (vif.xpos !== 10'd0 || vif.frame_start !== 1'b1) begin
         errors++;
         $display("FAIL mid_rel1: xpos %0d fs %b exp 0 1",
                  vif.xpos, vif.frame_start);
      end
      step();
      checks++;
      if (vif.xpos !== 10'd1 || vif.ypos !== 10'd0 ||
          vga_vsync !== 1'b1) begin
         errors++;
         $display("FAIL mid_rel2: pos %0d,%0d vs %b exp 1,0 1",
                  vif.xpos, vif.ypos, vga_vsync);
      end
   endtask

   initial begin
      test_reset();
      test_line();
      test_frame();
      test_rgb(1, "white");
      test_rgb(2, "xpos");
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
